// File: rtl/pipeline_stage_buf.sv
// -----------------------------------------------------------------------------
// pipeline_stage_buf
//
// Pipeline stage register for the CPU32 pipeline. Carries an opaque DATA_W-bit
// stage bundle across a valid/ready handshake. A two-entry skid buffer (main +
// skid) keeps in_ready a pure register output while still sustaining one beat
// per cycle. Adds per-beat NOP substitution (in_kill), a whole-stage flush, a
// free-running one-cycle sideband and a saturating stall counter.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       upstream beat present
//   in_ready   out  1       buffer can accept (registered)
//   in_data    in   DATA_W  upstream bundle
//   in_kill    in   1       store the accepted beat as NOP_VALUE
//   flush      in   1       discard all buffered beats at the next edge
//   out_valid  out  1       downstream beat present (registered)
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  head bundle, NOP_VALUE whenever out_valid=0
//   side_in    in   SIDE_W  sideband input
//   side_out   out  SIDE_W  side_in delayed one cycle
//   occupancy  out  2       buffered beats, 0..2 (registered)
//   stall_cnt  out  CNT_W   saturating count of out_valid && !out_ready cycles
// -----------------------------------------------------------------------------
module pipeline_stage_buf #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                SIDE_W    = 1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [SIDE_W-1:0] side_in,
  output logic [SIDE_W-1:0] side_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding equals the number of buffered beats, so occupancy is the
  // state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   w_main_next;
  logic [DATA_W-1:0]   r_skid;
  logic [DATA_W-1:0]   w_skid_next;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [SIDE_W-1:0]   r_side;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_in_xfer;
  logic                w_out_xfer;
  logic [DATA_W-1:0]   w_in_beat;

  // Flush blocks acceptance so a beat offered during the flush cycle is lost
  // rather than surviving into the emptied buffer.
  assign w_in_xfer  = in_valid && r_in_ready && !flush;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_in_beat  = in_kill ? NOP_VALUE : in_data;

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= NOP_VALUE;
      r_skid      <= NOP_VALUE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_main      <= w_main_next;
      r_skid      <= w_skid_next;
      // Handshake flags are decoded from the next state so they leave the
      // block straight from flops.
      r_out_valid <= (w_state_next != ST_EMPTY);
      r_in_ready  <= (w_state_next != ST_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_next = ST_ONE;
          w_main_next  = w_in_beat;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_next = w_in_beat;
        end else if (w_in_xfer) begin
          // Downstream stalled in the same cycle we accepted: catch the beat
          // in the skid entry; in_ready drops on the following cycle.
          w_state_next = ST_FULL;
          w_skid_next  = w_in_beat;
        end else if (w_out_xfer) begin
          w_state_next = ST_EMPTY;
          w_main_next  = NOP_VALUE;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          w_state_next = ST_ONE;
          w_main_next  = r_skid;
          w_skid_next  = NOP_VALUE;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
        w_main_next  = NOP_VALUE;
        w_skid_next  = NOP_VALUE;
      end
    endcase

    // Any same-cycle output transfer has already been seen downstream; the
    // buffer simply empties.
    if (flush) begin
      w_state_next = ST_EMPTY;
      w_main_next  = NOP_VALUE;
      w_skid_next  = NOP_VALUE;
    end
  end

  // ---------------------------------------------------------------------------
  // Sideband and stall counter (never flushed, cleared only by rst)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_side      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_side <= side_in;
      if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_state;
  assign side_out  = r_side;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_buf
//
// Directed, table-driven bench for pipeline_stage_buf. The main instance uses
// the default parameters; a second instance with CNT_W=4 exercises counter
// saturation. Inputs change 1 time unit after the rising edge and outputs are
// sampled at the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_kill;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [0:0]  side_in;
  logic [0:0]  side_out;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic [0:0]  s_side_out;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_stage_buf u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_kill   (in_kill),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .side_in   (side_in),
    .side_out  (side_out),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipeline_stage_buf #(.DATA_W(8), .CNT_W(4)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_kill   (1'b0),
    .flush     (1'b0),
    .out_valid (s_out_valid),
    .out_ready (1'b0),
    .out_data  (s_out_data),
    .side_in   (1'b0),
    .side_out  (s_side_out),
    .occupancy (s_occupancy),
    .stall_cnt (s_stall_cnt)
  );

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        ik;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic [63:0] ed;
    logic        erdy;
    logic [1:0]  eocc;
    logic [15:0] estall;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(logic iv, logic [63:0] id, logic ik, logic fl,
                              logic ordy, logic ev, logic [63:0] ed,
                              logic erdy, logic [1:0] eocc, logic [15:0] est);
    vec_t r;
    r.iv = iv; r.id = id; r.ik = ik; r.fl = fl; r.ordy = ordy;
    r.ev = ev; r.ed = ed; r.erdy = erdy; r.eocc = eocc; r.estall = est;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming 1..8 with out_ready=1
    vecs[0]  = mk(1, 64'h1, 0, 0, 1,  1, 64'h1, 1, 1, 0);
    vecs[1]  = mk(1, 64'h2, 0, 0, 1,  1, 64'h2, 1, 1, 0);
    vecs[2]  = mk(1, 64'h3, 0, 0, 1,  1, 64'h3, 1, 1, 0);
    vecs[3]  = mk(1, 64'h4, 0, 0, 1,  1, 64'h4, 1, 1, 0);
    vecs[4]  = mk(1, 64'h5, 0, 0, 1,  1, 64'h5, 1, 1, 0);
    vecs[5]  = mk(1, 64'h6, 0, 0, 1,  1, 64'h6, 1, 1, 0);
    vecs[6]  = mk(1, 64'h7, 0, 0, 1,  1, 64'h7, 1, 1, 0);
    vecs[7]  = mk(1, 64'h8, 0, 0, 1,  1, 64'h8, 1, 1, 0);
    vecs[8]  = mk(0, 64'h0, 0, 0, 1,  0, 64'h0, 1, 0, 0);
    // Backpressure: fill to FULL, hold (offered beat with kill is ignored), drain
    vecs[9]  = mk(1, 64'h31, 0, 0, 0, 1, 64'h31, 1, 1, 0);
    vecs[10] = mk(1, 64'h32, 0, 0, 0, 1, 64'h31, 0, 2, 1);
    vecs[11] = mk(1, 64'h33, 1, 0, 0, 1, 64'h31, 0, 2, 2);
    vecs[12] = mk(1, 64'h33, 0, 0, 0, 1, 64'h31, 0, 2, 3);
    vecs[13] = mk(1, 64'h33, 0, 0, 1, 1, 64'h32, 1, 1, 3);
    vecs[14] = mk(1, 64'h33, 0, 0, 1, 1, 64'h33, 1, 1, 3);
    vecs[15] = mk(0, 64'h0,  0, 0, 1, 0, 64'h0,  1, 0, 3);
    // Kill: 0x11, killed 0xAA -> NOP, 0x22
    vecs[16] = mk(1, 64'h11, 0, 0, 1, 1, 64'h11, 1, 1, 3);
    vecs[17] = mk(1, 64'hAA, 1, 0, 1, 1, 64'h0,  1, 1, 3);
    vecs[18] = mk(1, 64'h22, 0, 0, 1, 1, 64'h22, 1, 1, 3);
    vecs[19] = mk(0, 64'h0,  0, 0, 1, 0, 64'h0,  1, 0, 3);
    // Flush while FULL with 0x55 offered, then flush in ONE with 0x55 offered
    vecs[20] = mk(1, 64'h61, 0, 0, 0, 1, 64'h61, 1, 1, 3);
    vecs[21] = mk(1, 64'h62, 0, 0, 0, 1, 64'h61, 0, 2, 4);
    vecs[22] = mk(1, 64'h55, 0, 1, 0, 0, 64'h0,  1, 0, 5);
    vecs[23] = mk(1, 64'h70, 0, 0, 1, 1, 64'h70, 1, 1, 5);
    vecs[24] = mk(1, 64'h55, 0, 1, 1, 0, 64'h0,  1, 0, 5);
    vecs[25] = mk(0, 64'h0,  0, 0, 1, 0, 64'h0,  1, 0, 5);

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_kill = 1'b0; flush = 1'b0;
    out_ready = 1'b0; side_in = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  out_data,       64'h0);
    chk("rst_in_ready",  64'(in_ready),  64'h1);
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    chk("rst_side_out",  64'(side_out),  64'h0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      logic si;
      si = (i % 3 == 0);
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      in_kill   = vecs[i].ik;
      flush     = vecs[i].fl;
      out_ready = vecs[i].ordy;
      side_in   = si;
      step();
      $display("vec %0d: in_v=%0d in=0x%0h kill=%0d flush=%0d ordy=%0d -> out_v=%0d out=0x%0h rdy=%0d occ=%0d stall=%0d",
               i, vecs[i].iv, vecs[i].id, vecs[i].ik, vecs[i].fl, vecs[i].ordy,
               out_valid, out_data, in_ready, occupancy, stall_cnt);
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d_out_data", i),  out_data,       vecs[i].ed);
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].erdy));
      chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
      chk($sformatf("v%0d_side_out", i),  64'(side_out),  64'(si));
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].estall));
    end

    // Async reset while FULL, asserted between edges
    in_valid = 1'b1; in_data = 64'h81; in_kill = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step();
    in_data = 64'h82;
    step();
    $display("fill for reset: out_v=%0d out=0x%0h occ=%0d", out_valid, out_data, occupancy);
    chk("arst_pre_occ",  64'(occupancy), 64'h2);
    chk("arst_pre_data", out_data,       64'h81);
    chk("arst_pre_stall", 64'(stall_cnt), 64'h6);
    in_valid = 1'b0;
    side_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: out_v=%0d out=0x%0h rdy=%0d occ=%0d", out_valid, out_data, in_ready, occupancy);
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_out_data",  out_data,       64'h0);
    chk("arst_in_ready",  64'(in_ready),  64'h1);
    chk("arst_occupancy", 64'(occupancy), 64'h0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("arst_side_out",  64'(side_out),  64'h0);
    // Handshake offered while rst is held must be ignored
    in_valid = 1'b1; in_data = 64'h99; out_ready = 1'b1;
    step();
    chk("arst_hold_valid", 64'(out_valid), 64'h0);
    chk("arst_hold_side",  64'(side_out),  64'h0);
    in_data = 64'h90;
    #2;
    rst = 1'b0;
    step();
    $display("post reset beat: out_v=%0d out=0x%0h occ=%0d", out_valid, out_data, occupancy);
    chk("prst_out_valid", 64'(out_valid), 64'h1);
    chk("prst_out_data",  out_data,       64'h90);
    chk("prst_occupancy", 64'(occupancy), 64'h1);
    in_valid = 1'b0;
    step();
    chk("prst_drain_valid", 64'(out_valid), 64'h0);
    chk("prst_drain_data",  out_data,       64'h0);

    // Saturation on the CNT_W=4 instance (out_ready tied low)
    s_in_valid = 1'b1; s_in_data = 8'h5A;
    step();
    s_in_valid = 1'b0;
    $display("sat load: out_v=%0d out=0x%0h stall=%0d", s_out_valid, s_out_data, s_stall_cnt);
    chk("sat_valid",  64'(s_out_valid), 64'h1);
    chk("sat_data",   64'(s_out_data),  64'h5A);
    chk("sat_start",  64'(s_stall_cnt), 64'h0);
    repeat (14) step();
    $display("sat after 14 stalls: stall=%0d", s_stall_cnt);
    chk("sat_14", 64'(s_stall_cnt), 64'd14);
    repeat (6) step();
    $display("sat after 20 stalls: stall=%0d", s_stall_cnt);
    chk("sat_20", 64'(s_stall_cnt), 64'd15);
    chk("sat_occ", 64'(s_occupancy), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buf.md
# pipeline_stage_buf

Parametrised pipeline stage register for the CPU32 pipeline, successor to the fixed-field decode→execute/memory/writeback latch. It carries an opaque DATA_W-bit bundle of stage control and operands, with a valid/ready handshake so downstream stages can stall. A two-entry skid buffer keeps in_ready registered while still sustaining one beat per cycle. The block also provides per-beat NOP substitution (kill), a whole-stage flush, a free-running sideband bit, and a saturating stall counter for performance monitoring.

## Interface
- DATA_W, 64: width of the stage bundle (operands, ALU op, cond, flags, regfile ops, packed by the instantiator).
- NOP_VALUE, {DATA_W{1'b0}}: bundle encoding of a clean NOP; all-zero matches the existing ALU/mem/regfile NOP codes.
- SIDE_W, 1: width of the unflushed sideband (pcincr-style).
- CNT_W, 16: stall counter width.
- clk  in  1  clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  buffer can accept; registered.
- in_data  in  DATA_W  upstream bundle.
- in_kill  in  1  qualifies the current input beat; when high, the beat is accepted but stored as NOP_VALUE.
- flush  in  1  discard all buffered beats.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head bundle; NOP_VALUE whenever out_valid=0.
- side_in  in  SIDE_W  sideband input.
- side_out  out  SIDE_W  side_in delayed one cycle.
- occupancy  out  2  number of buffered beats, 0..2.
- stall_cnt  out  CNT_W  count of cycles with out_valid && !out_ready.

## Operation
- Storage: main entry (head, drives out_*) and skid entry. in_ready = !skid_valid.
- Input transfer: in_valid && in_ready && !flush. The stored bundle is in_kill ? NOP_VALUE : in_data. A killed beat still occupies a slot and emerges with out_valid=1.
- Output transfer: out_valid && out_ready.
- State: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - EMPTY + input transfer → ONE; the beat goes to main.
  - ONE + input only → FULL if output is stalled; the new beat goes to skid.
  - ONE + output only → EMPTY.
  - ONE + input and output → ONE; main is replaced by the new beat.
  - FULL + output → ONE; skid moves to main. in_ready is 0, so no input is possible.
  - FULL + no output → hold.
- Ordering is strictly FIFO. No beat is duplicated or lost except through flush.
- flush (synchronous) → EMPTY next cycle. It overrides any same-cycle input transfer. A same-cycle output transfer still completes downstream; the beat on the bus that cycle is valid.
- in_kill is ignored when no input transfer occurs.
- side_out <= side_in every cycle, regardless of handshake, flush or kill.
- stall_cnt increments on each cycle with out_valid && !out_ready, saturates at all-ones, and is cleared only by rst.
- rst (asynchronous, any time including mid-transfer): both entries are invalidated immediately.
  - Reset values: out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0, side_out=0, stall_cnt=0.
  - Handshakes are ignored while rst is high.

## Timing
- Latency: 1 cycle from input transfer to out_valid when EMPTY.
- Throughput: 1 beat/cycle when out_ready is held high.
- in_ready, out_valid, out_data and occupancy are register outputs; no combinational in→out path.
- in_ready falls the cycle after the buffer reaches FULL. A beat accepted in the cycle out_ready drops is caught by the skid entry.
- flush takes effect at the next edge. occupancy reads 0 and in_ready reads 1 the following cycle.
- side_out: fixed latency of 1 cycle.

## Test plan
- Streaming: out_ready=1, 8 beats 0x1..0x8 back-to-back → out_data 0x1..0x8 on consecutive cycles starting 1 cycle after the first beat, occupancy ≤1, stall_cnt=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid held → 2 beats accepted, in_ready=0 and occupancy=2 from the cycle after the second accept, stall_cnt=3. On release, both beats are delivered in order with no loss.
- Kill: beat 0xAA with in_kill=1 between 0x11 and 0x22 → output sequence 0x11, NOP_VALUE (out_valid=1), 0x22.
- Flush while FULL with a simultaneous in_valid=1 carrying 0x55 → occupancy=0 next cycle and 0x55 never appears. side_out keeps tracking side_in with 1-cycle delay.
- Async reset: rst asserted between edges while FULL → out_valid=0 and out_data=NOP_VALUE immediately, without waiting for a clock edge. After release, the first accepted beat appears 1 cycle later.
- Saturation: CNT_W=4, out_valid stalled for 20 cycles → stall_cnt holds at 15.
